aznable_cen_gen: RTL and testbench

Multi-channel fractional clock-enable generator for the Aznable system. It generalises the fixed 24 MHz divider that produces the 6 MHz and 2 MHz enables into CHANNELS independent enables. Each enable has a programmable rate of num/den of clk_sys, with per-channel pause gating and a phase re-sync. It sits between the system clock and the system/pause logic and drives every ce_* strobe.

---
 rtl/aznable_cen_gen.sv | 68 ++++++
 tb/tb_aznable_cen_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aznable_cen_gen.sv
// rtl/aznable_cen_gen.sv - multi-channel fractional clock-enable generator
// Each channel pulses cen at num/den of clk_sys using a wrap-around accumulator.
module aznable_cen_gen #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 8,
  parameter logic [CHANNELS*ACC_W-1:0] DEF_NUM = {8'd1, 8'd1, 8'd1, 8'd1},
  parameter logic [CHANNELS*ACC_W-1:0] DEF_DEN = {8'd1, 8'd2, 8'd12, 8'd4}
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                pause,
  input  logic [CHANNELS-1:0] pause_mask,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [2:0]          cfg_sel,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] active
);

  logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W-1:0] num_q, num_d;
  logic [CHANNELS-1:0][ACC_W-1:0] den_q, den_d;
  logic [CHANNELS-1:0]            cen_q, cen_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ACC_W-1:0] num_eff;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] wrap;
    logic             hit;
    logic             sel_hit;

    // Numerators above den are clamped so the channel saturates at one pulse per cycle.
    assign num_eff = (num_q[g] > den_q[g]) ? den_q[g] : num_q[g];
    assign sum     = {1'b0, acc_q[g]} + {1'b0, num_eff};
    assign wrap    = acc_q[g] + num_eff - den_q[g];
    assign hit     = (sum >= {1'b0, den_q[g]});
    assign sel_hit = cfg_wr && (cfg_sel == 3'(g));

    assign active[g] = (den_q[g] != '0) && !(pause && pause_mask[g]);

    // Sync and config writes restart the phase; the pulse for this edge still uses the old rate.
    assign acc_d[g] = (sync || sel_hit) ? '0
                    : active[g]         ? (hit ? wrap : sum[ACC_W-1:0])
                    :                     acc_q[g];
    assign cen_d[g] = !sync && active[g] && hit;
    assign num_d[g] = sel_hit ? cfg_num : num_q[g];
    assign den_d[g] = sel_hit ? cfg_den : den_q[g];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cen_q <= '0;
      num_q <= DEF_NUM;
      den_q <= DEF_DEN;
    end else begin
      acc_q <= acc_d;
      cen_q <= cen_d;
      num_q <= num_d;
      den_q <= den_d;
    end
  end

  assign cen = cen_q;

endmodule

// File: tb/tb_aznable_cen_gen.sv
// tb/tb_aznable_cen_gen.sv - self-checking bench for aznable_cen_gen
// Reference model: pulse when floor((n+1)*num_eff/den) advances, n = active cycles since phase reset.
module tb_aznable_cen_gen;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          pause = 1'b0;
  logic [CH-1:0] pause_mask = '0;
  logic          sync = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_sel = '0;
  logic [W-1:0]  cfg_num = '0;
  logic [W-1:0]  cfg_den = '0;
  logic [CH-1:0] cen;
  logic [CH-1:0] active;

  int total = 0;
  int bad = 0;
  int m_num[CH];
  int m_den[CH];
  int m_n[CH];
  int cnt0, cnt1;

  always #5 clk_sys = ~clk_sys;

  aznable_cen_gen dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .pause      (pause),
    .pause_mask (pause_mask),
    .sync       (sync),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_num    (cfg_num),
    .cfg_den    (cfg_den),
    .cen        (cen),
    .active     (active)
  );

  function automatic void model_reset();
    m_num = '{1, 1, 1, 1};
    m_den = '{4, 12, 2, 1};
    m_n   = '{0, 0, 0, 0};
  endfunction

  function automatic int ne(int i);
    return (m_num[i] > m_den[i]) ? m_den[i] : m_num[i];
  endfunction

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk_sys edge: predict, check active before the edge and cen after it, drop strobes.
  task automatic tick();
    logic [CH-1:0] ea, ec;
    logic act, hitsel;
    ea = '0;
    ec = '0;
    for (int i = 0; i < CH; i++) begin
      act    = (m_den[i] != 0) && !(pause && pause_mask[i]);
      hitsel = cfg_wr && (int'(cfg_sel) == i);
      ea[i]  = act;
      if (!sync && act)
        ec[i] = (((m_n[i] + 1) * ne(i)) / m_den[i]) != ((m_n[i] * ne(i)) / m_den[i]);
      if (sync || hitsel) m_n[i] = 0;
      else if (act)       m_n[i] = (m_n[i] + 1) % m_den[i];
      if (hitsel) begin
        m_num[i] = int'(cfg_num);
        m_den[i] = int'(cfg_den);
      end
    end
    #1;
    check("active", active, ea);
    @(posedge clk_sys);
    #1;
    check("cen", cen, ec);
    if (cen[0] === 1'b1) cnt0++;
    if (cen[1] === 1'b1) cnt1++;
    cfg_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic cfg(input int sel, input int num, input int den);
    cfg_wr  = 1'b1;
    cfg_sel = 3'(sel);
    cfg_num = W'(num);
    cfg_den = W'(den);
    tick();
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_cen", cen, 4'b0000);
    check("reset_active", active, 4'b1111);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;

    // Defaults: 6/2/12/24 MHz from 24 MHz
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 24; k++) tick();
    check_int("def_ch0_count", cnt0, 6);
    check_int("def_ch1_count", cnt1, 2);

    // Fractional 3/8
    cfg(0, 3, 8);
    cnt0 = 0;
    for (int k = 0; k < 80; k++) tick();
    check_int("frac_count", cnt0, 30);

    // Pause mid-count on ch0 at 1/4
    cfg(0, 1, 4);
    tick();
    tick();
    pause = 1'b1;
    pause_mask = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    pause = 1'b0;
    tick();
    check("pause_rel_1", {3'b000, cen[0]}, 4'b0000);
    tick();
    check("pause_rel_2", {3'b000, cen[0]}, 4'b0001);
    for (int k = 0; k < 6; k++) tick();

    // Clamp, disable, out-of-range select
    cfg(1, 9, 4);
    for (int k = 0; k < 5; k++) tick();
    check("clamp_ch1", {3'b000, cen[1]}, 4'b0001);
    cfg(1, 3, 0);
    for (int k = 0; k < 8; k++) tick();
    check("disable_active", {3'b000, active[1]}, 4'b0000);
    cfg(5, 7, 7);
    for (int k = 0; k < 4; k++) tick();
    cfg(1, 1, 12);

    // Sync at an arbitrary phase
    for (int k = 0; k < 7; k++) tick();
    sync = 1'b1;
    tick();
    for (int k = 0; k < 13; k++) tick();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      pause      = ($urandom % 4) == 0;
      pause_mask = CH'($urandom);
      sync       = ($urandom % 20) == 0;
      if (($urandom % 8) == 0) begin
        cfg_wr  = 1'b1;
        cfg_sel = 3'($urandom % 8);
        cfg_num = W'($urandom % 12);
        cfg_den = W'($urandom % 10);
      end
      tick();
    end
    pause = 1'b0;
    pause_mask = '0;

    // Asynchronous reset mid-cycle while ch3 is pulsing
    cfg(3, 1, 1);
    tick();
    check("pre_rst_ch3", {3'b000, cen[3]}, 4'b0001);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_cen", cen, 4'b0000);
    model_reset();
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 24; k++) tick();
    check_int("rst_ch0_count", cnt0, 6);
    check_int("rst_ch1_count", cnt1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
